// File: rtl/ps2_key_sequencer_pkg.sv
// Shared definitions for the PS/2 key sequencer: prefix and status byte codes,
// FSM state encoding and the packed key-event record.
package ps2_key_sequencer_pkg;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_t;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } key_event_t;

    localparam int EVENT_W = $bits(key_event_t);

    // Keyboard protocol/status replies that never carry a key.
    function automatic logic is_status(input logic [7:0] b);
        case (b)
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF, 8'hE1: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word-fall-through event FIFO; pop_data is the head, zero while empty.
// Push when full is accepted only if a pop frees a slot in the same cycle.
module ps2_event_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign empty    = (cnt == '0);
    assign full     = (cnt == FULL_CNT);
    assign count    = cnt;
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/ps2_key_sequencer.sv
// Turns the raw PS/2 scancode stream into {code, ext, brk} key events with
// typematic-repeat filtering, prefix timeout and a buffered valid/ready output.
module ps2_key_sequencer
    import ps2_key_sequencer_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 50000,
    parameter int FILTER_REP  = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    rx_byte,
    input  logic                          rx_valid,
    output logic                          ev_valid,
    input  logic                          ev_ready,
    output logic [7:0]                    ev_code,
    output logic                          ev_ext,
    output logic                          ev_brk,
    output logic [$clog2(FIFO_DEPTH):0]   ev_count,
    output logic                          ovf,
    input  logic                          ovf_clr,
    output logic                          seq_err
);
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);

    state_t      state;
    logic [TW-1:0] timer;
    logic [7:0]  held_code;
    logic        held_ext;
    logic        held_vld;

    key_event_t  ev_in;
    key_event_t  ev_head;
    logic        is_prefix;
    logic        rx_status;
    logic        emit;
    logic        held_match;
    logic        suppress;
    logic        push;
    logic        pop;
    logic        fifo_full;
    logic        fifo_empty;

    assign is_prefix = (rx_byte == PS2_EXT) || (rx_byte == PS2_BRK);
    assign rx_status = is_status(rx_byte);

    // Any non-prefix, non-status byte completes an event; the state supplies ext/brk.
    always_comb begin
        ev_in      = '0;
        ev_in.code = rx_byte;
        ev_in.ext  = (state == ST_EXT) || (state == ST_EXT_BRK);
        ev_in.brk  = (state == ST_BRK) || (state == ST_EXT_BRK);
    end

    assign emit       = rx_valid && !rx_status && !is_prefix;
    assign held_match = held_vld && (held_code == rx_byte) && (held_ext == ev_in.ext);
    assign suppress   = (FILTER_REP != 0) && !ev_in.brk && held_match;
    assign push       = emit && !suppress;
    assign pop        = ev_valid && ev_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            timer   <= '0;
            seq_err <= 1'b0;
        end else begin
            seq_err <= 1'b0;
            if (rx_valid) begin
                // A byte arriving on the expiry cycle is still processed normally.
                timer <= '0;
                if (rx_status) begin
                    state <= ST_IDLE;
                end else begin
                    case (state)
                        ST_IDLE: begin
                            if (rx_byte == PS2_EXT)
                                state <= ST_EXT;
                            else if (rx_byte == PS2_BRK)
                                state <= ST_BRK;
                        end
                        ST_EXT: begin
                            if (rx_byte == PS2_BRK)
                                state <= ST_EXT_BRK;
                            else if (rx_byte != PS2_EXT)
                                state <= ST_IDLE;
                        end
                        ST_BRK, ST_EXT_BRK: begin
                            seq_err <= is_prefix;
                            state   <= ST_IDLE;
                        end
                        default: state <= ST_IDLE;
                    endcase
                end
            end else if (state == ST_IDLE) begin
                timer <= '0;
            end else if (timer == TMAX) begin
                state   <= ST_IDLE;
                seq_err <= 1'b1;
                timer   <= '0;
            end else begin
                timer <= timer + TW'(1);
            end
        end
    end

    // Held key tracks the last make that passed the filter, even if the FIFO dropped it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            held_code <= '0;
            held_ext  <= 1'b0;
            held_vld  <= 1'b0;
        end else if (emit && !ev_in.brk && !suppress) begin
            held_code <= rx_byte;
            held_ext  <= ev_in.ext;
            held_vld  <= 1'b1;
        end else if (emit && ev_in.brk && held_match) begin
            held_vld  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ovf <= 1'b0;
        else if (push && fifo_full && !pop)
            ovf <= 1'b1;
        else if (ovf_clr)
            ovf <= 1'b0;
    end

    ps2_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVENT_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (ev_in),
        .pop       (pop),
        .pop_data  (ev_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (ev_count)
    );

    assign ev_valid = !fifo_empty;
    assign ev_code  = ev_head.code;
    assign ev_ext   = ev_head.ext;
    assign ev_brk   = ev_head.brk;

endmodule
